// File: rtl/mac_dot_sequencer_if.sv
// mac_dot_sequencer_if
//   Bundles the signals around the dot-product sequencer: the host
//   control/operand stream, the result handshake, and the link to the
//   external 4x4 multiplier.
//   Modports:
//     master : host side (drives start/len/abort, operand stream, res_ready)
//     mult   : multiplier datapath (sees mul_a/mul_b, returns mul_p)
//     slave  : the sequencer itself
interface mac_dot_sequencer_if #(
    parameter int LEN_W = 4,
    parameter int ACC_W = 12
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             abort;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       a;
    logic [3:0]       b;
    logic [3:0]       mul_a;
    logic [3:0]       mul_b;
    logic [7:0]       mul_p;
    logic             res_valid;
    logic             res_ready;
    logic [ACC_W-1:0] result;
    logic             overflow;

    modport master (
        output start, len, abort, in_valid, a, b, res_ready,
        input  busy, in_ready, res_valid, result, overflow
    );

    modport mult (
        input  mul_a, mul_b,
        output mul_p
    );

    modport slave (
        input  start, len, abort, in_valid, a, b, res_ready, mul_p,
        output busy, in_ready, res_valid, result, overflow, mul_a, mul_b
    );
endinterface

// File: rtl/mac_dot_sequencer.sv
// mac_dot_sequencer
//   Walks an external 4x4 unsigned multiplier through an N-element dot
//   product. Operand pairs arrive on a valid/ready stream, are registered
//   onto mul_a/mul_b, and the returned product is accumulated one cycle
//   later. The final sum is offered on a valid/ready result handshake.
//   Ports:
//     clk  : clock, rising edge
//     rst  : asynchronous, active-high reset
//     bus  : mac_dot_sequencer_if.slave (control, operand stream,
//            multiplier link, result handshake)
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for start; result holds the last sum
//   RUN   | accepting operand pairs, cnt counts remaining pairs down
//   DRAIN | last product in flight, accumulated at end of this cycle
//   DONE  | result valid and held until res_ready
module mac_dot_sequencer #(
    parameter int LEN_W = 4,
    parameter int ACC_W = 12,
    parameter int SAT   = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    mac_dot_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [LEN_W-1:0]   r_cnt;
    logic [ACC_W-1:0]   r_acc;
    logic               r_ovf;
    logic               r_op_vld;
    logic [3:0]         r_mul_a;
    logic [3:0]         r_mul_b;

    logic               w_in_ready;
    logic               w_hs;
    logic               w_last;
    logic [ACC_W:0]     w_sum;
    logic               w_carry;
    logic [ACC_W-1:0]   w_acc_nxt;

    // abort wins over a handshake in the same cycle, so the stream is not
    // told a pair was taken when it is about to be discarded
    assign w_in_ready = (r_state == S_RUN) && !bus.abort;
    assign w_hs       = bus.in_valid && w_in_ready;
    assign w_last     = (r_cnt == LEN_W'(1));

    // one extra bit on the adder exposes the carry out of the accumulator
    assign w_sum      = {1'b0, r_acc} + {{(ACC_W - 7){1'b0}}, bus.mul_p};
    assign w_carry    = w_sum[ACC_W];
    // once pinned at all-ones any further non-zero product carries again,
    // so saturation is self-sustaining without a separate flag
    assign w_acc_nxt  = (w_carry && (SAT != 0)) ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (bus.abort) begin
            w_state_nxt = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE:  if (bus.start) w_state_nxt = (bus.len != '0) ? S_RUN : S_DONE;
                S_RUN:   if (w_hs && w_last) w_state_nxt = S_DRAIN;
                S_DRAIN: w_state_nxt = S_DONE;
                S_DONE:  if (bus.res_ready) w_state_nxt = S_IDLE;
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (r_state != S_IDLE);
        bus.in_ready  = w_in_ready;
        bus.res_valid = (r_state == S_DONE);
        bus.result    = r_acc;
        bus.overflow  = r_ovf;
        bus.mul_a     = r_mul_a;
        bus.mul_b     = r_mul_b;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_op_vld <= 1'b0;
            r_mul_a  <= '0;
            r_mul_b  <= '0;
        end else if (bus.abort) begin
            r_cnt    <= '0;
            r_acc    <= '0;
            r_ovf    <= 1'b0;
            r_op_vld <= 1'b0;
        end else begin
            r_op_vld <= w_hs;
            if (w_hs) begin
                r_mul_a <= bus.a;
                r_mul_b <= bus.b;
                r_cnt   <= r_cnt - LEN_W'(1);
            end
            // w_hs is never set in IDLE, so the cnt load cannot collide
            if ((r_state == S_IDLE) && bus.start) begin
                r_acc <= '0;
                r_ovf <= 1'b0;
                r_cnt <= bus.len;
            end else if (r_op_vld) begin
                r_acc <= w_acc_nxt;
                if (w_carry) begin
                    r_ovf <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_mac_dot_sequencer.sv
module tb_mac_dot_sequencer;

    typedef struct {
        int len;
        int gap;
        int hold;
        int poke;
        int a[16];
        int b[16];
        int r12;
        int o12;
        int r8s;
        int o8s;
        int r8w;
        int o8w;
    } vec_t;

    logic       clk;
    logic       t_rst;
    logic       t_start;
    logic [3:0] t_len;
    logic       t_abort;
    logic       t_in_valid;
    logic [3:0] t_a;
    logic [3:0] t_b;
    logic       t_res_ready;

    int checks;
    int errors;
    int hs_cnt;
    vec_t v[8];
    vec_t sb[$];

    mac_dot_sequencer_if #(.LEN_W(4), .ACC_W(12)) bus12 ();
    mac_dot_sequencer_if #(.LEN_W(4), .ACC_W(8))  bus8s ();
    mac_dot_sequencer_if #(.LEN_W(4), .ACC_W(8))  bus8w ();

    mac_dot_sequencer #(.LEN_W(4), .ACC_W(12), .SAT(1)) u_dut12 (.clk(clk), .rst(t_rst), .bus(bus12));
    mac_dot_sequencer #(.LEN_W(4), .ACC_W(8),  .SAT(1)) u_dut8s (.clk(clk), .rst(t_rst), .bus(bus8s));
    mac_dot_sequencer #(.LEN_W(4), .ACC_W(8),  .SAT(0)) u_dut8w (.clk(clk), .rst(t_rst), .bus(bus8w));

    assign bus12.start = t_start;   assign bus8s.start = t_start;   assign bus8w.start = t_start;
    assign bus12.len = t_len;       assign bus8s.len = t_len;       assign bus8w.len = t_len;
    assign bus12.abort = t_abort;   assign bus8s.abort = t_abort;   assign bus8w.abort = t_abort;
    assign bus12.in_valid = t_in_valid; assign bus8s.in_valid = t_in_valid; assign bus8w.in_valid = t_in_valid;
    assign bus12.a = t_a;           assign bus8s.a = t_a;           assign bus8w.a = t_a;
    assign bus12.b = t_b;           assign bus8s.b = t_b;           assign bus8w.b = t_b;
    assign bus12.res_ready = t_res_ready; assign bus8s.res_ready = t_res_ready; assign bus8w.res_ready = t_res_ready;
    assign bus12.mul_p = {4'b0, bus12.mul_a} * {4'b0, bus12.mul_b};
    assign bus8s.mul_p = {4'b0, bus8s.mul_a} * {4'b0, bus8s.mul_b};
    assign bus8w.mul_p = {4'b0, bus8w.mul_a} * {4'b0, bus8w.mul_b};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0d required %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input int len, input int gap, input int hold, input int poke,
                                input int r12, input int o12, input int r8s, input int o8s,
                                input int r8w, input int o8w);
        vec_t x;
        x.len = len; x.gap = gap; x.hold = hold; x.poke = poke;
        x.r12 = r12; x.o12 = o12; x.r8s = r8s; x.o8s = o8s; x.r8w = r8w; x.o8w = o8w;
        for (int i = 0; i < 16; i++) begin
            x.a[i] = 0;
            x.b[i] = 0;
        end
        return x;
    endfunction

    // scoreboard: pop and compare whenever a result is taken
    always @(negedge clk) begin
        if (!t_rst) begin
            if (t_in_valid && bus12.in_ready) hs_cnt++;
            if (!bus12.busy) chk("in_ready_idle", int'(bus12.in_ready), 0);
            if (bus12.res_valid && t_res_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", int'(bus12.res_valid), 0);
                end else begin
                    vec_t e;
                    e = sb.pop_front();
                    chk("result_acc12", int'(bus12.result), e.r12);
                    chk("overflow_acc12", int'(bus12.overflow), e.o12);
                    chk("res_valid_sat8", int'(bus8s.res_valid), 1);
                    chk("result_sat8", int'(bus8s.result), e.r8s);
                    chk("overflow_sat8", int'(bus8s.overflow), e.o8s);
                    chk("res_valid_wrap8", int'(bus8w.res_valid), 1);
                    chk("result_wrap8", int'(bus8w.result), e.r8w);
                    chk("overflow_wrap8", int'(bus8w.overflow), e.o8w);
                end
            end
        end
    end

    task automatic run_vec(input vec_t x);
        int hs0;
        bit got;
        hs0 = hs_cnt;
        sb.push_back(x);
        t_res_ready = (x.hold == 0);
        t_start = 1'b1;
        t_len = 4'(x.len);
        @(posedge clk); #1;
        t_start = 1'b0;
        if (x.len == 0) begin
            @(negedge clk);
            chk("len0_res_valid", int'(bus12.res_valid), 1);
            chk("len0_in_ready", int'(bus12.in_ready), 0);
            chk("len0_result", int'(bus12.result), 0);
        end else begin
            for (int i = 0; i < x.len; i++) begin
                t_in_valid = 1'b1;
                t_a = 4'(x.a[i]);
                t_b = 4'(x.b[i]);
                got = 1'b0;
                for (int w = 0; w < 8 && !got; w++) begin
                    @(negedge clk);
                    if (bus12.in_ready) got = 1'b1;
                    @(posedge clk); #1;
                end
                if (!got) chk("handshake_timeout", 0, 1);
                t_in_valid = 1'b0;
                if (i < x.len - 1) begin
                    repeat (x.gap) begin
                        @(posedge clk); #1;
                    end
                end
            end
            @(negedge clk);
            chk("drain_res_valid", int'(bus12.res_valid), 0);
            chk("drain_busy", int'(bus12.busy), 1);
            chk("drain_in_ready", int'(bus12.in_ready), 0);
            @(negedge clk);
            chk("latency_res_valid", int'(bus12.res_valid), 1);
        end
        for (int h = 0; h < x.hold; h++) begin
            @(posedge clk); #1;
            t_start = (x.poke != 0) && (h == 1);
            t_len = 4'd3;
            t_in_valid = 1'b1;
            @(negedge clk);
            chk("hold_res_valid", int'(bus12.res_valid), 1);
            chk("hold_result", int'(bus12.result), x.r12);
            chk("hold_in_ready", int'(bus12.in_ready), 0);
        end
        if (x.hold != 0) begin
            @(posedge clk); #1;
            t_start = 1'b0;
            t_in_valid = 1'b0;
            t_res_ready = 1'b1;
        end
        @(posedge clk); #1;
        t_res_ready = 1'b0;
        @(negedge clk);
        chk("after_busy", int'(bus12.busy), 0);
        chk("after_res_valid", int'(bus12.res_valid), 0);
        chk("after_result_kept", int'(bus12.result), x.r12);
        chk("pairs_taken", hs_cnt - hs0, x.len);
        chk("one_result_only", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        hs_cnt = 0;
        t_rst = 1'b1;
        t_start = 1'b0;
        t_len = 4'd0;
        t_abort = 1'b0;
        t_in_valid = 1'b0;
        t_a = 4'd0;
        t_b = 4'd0;
        t_res_ready = 1'b0;

        v[0] = mk(3, 0, 0, 0, 254, 0, 254, 0, 254, 0);
        v[0].a[0] = 3;  v[0].b[0] = 5;
        v[0].a[1] = 15; v[0].b[1] = 15;
        v[0].a[2] = 2;  v[0].b[2] = 7;
        v[1] = mk(4, 1, 5, 1, 30, 0, 30, 0, 30, 0);
        for (int i = 0; i < 4; i++) begin
            v[1].a[i] = i + 1;
            v[1].b[i] = i + 1;
        end
        v[2] = mk(2, 0, 0, 0, 450, 0, 255, 1, 194, 1);
        v[2].a[0] = 15; v[2].b[0] = 15;
        v[2].a[1] = 15; v[2].b[1] = 15;
        v[3] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        v[4] = mk(1, 0, 0, 0, 16, 0, 16, 0, 16, 0);
        v[4].a[0] = 4; v[4].b[0] = 4;
        v[5] = mk(1, 0, 0, 0, 81, 0, 81, 0, 81, 0);
        v[5].a[0] = 9; v[5].b[0] = 9;
        v[6] = mk(15, 0, 0, 0, 3375, 0, 255, 1, 47, 1);
        for (int i = 0; i < 15; i++) begin
            v[6].a[i] = 15;
            v[6].b[i] = 15;
        end
        v[7] = mk(2, 2, 2, 0, 0, 0, 0, 0, 0, 0);
        v[7].a[0] = 0; v[7].b[0] = 9;
        v[7].a[1] = 7; v[7].b[1] = 0;

        #2;
        chk("rst_busy", int'(bus12.busy), 0);
        chk("rst_in_ready", int'(bus12.in_ready), 0);
        chk("rst_res_valid", int'(bus12.res_valid), 0);
        chk("rst_result", int'(bus12.result), 0);
        chk("rst_overflow", int'(bus12.overflow), 0);
        chk("rst_mul_a", int'(bus12.mul_a), 0);
        chk("rst_mul_b", int'(bus12.mul_b), 0);
        @(posedge clk); #1;
        t_rst = 1'b0;
        @(posedge clk); #1;

        for (int k = 0; k < 4; k++) run_vec(v[k]);
        run_vec(v[6]);
        run_vec(v[7]);

        // abort after one accepted pair
        t_start = 1'b1;
        t_len = 4'd4;
        @(posedge clk); #1;
        t_start = 1'b0;
        t_in_valid = 1'b1;
        t_a = 4'd5;
        t_b = 4'd3;
        @(posedge clk); #1;
        t_in_valid = 1'b0;
        t_abort = 1'b1;
        @(posedge clk); #1;
        t_abort = 1'b0;
        @(negedge clk);
        chk("abort_busy", int'(bus12.busy), 0);
        chk("abort_in_ready", int'(bus12.in_ready), 0);
        chk("abort_res_valid", int'(bus12.res_valid), 0);
        chk("abort_result", int'(bus12.result), 0);
        chk("abort_overflow", int'(bus12.overflow), 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_res_valid_stays", int'(bus12.res_valid), 0);
        end
        @(posedge clk); #1;
        run_vec(v[4]);

        // async reset between clock edges
        t_start = 1'b1;
        t_len = 4'd3;
        @(posedge clk); #1;
        t_start = 1'b0;
        t_in_valid = 1'b1;
        t_a = 4'd7;
        t_b = 4'd6;
        @(posedge clk); #1;
        t_in_valid = 1'b0;
        @(posedge clk); #2;
        chk("pre_rst_result", int'(bus12.result), 42);
        chk("pre_rst_mul_a", int'(bus12.mul_a), 7);
        t_rst = 1'b1;
        #1;
        chk("async_rst_busy", int'(bus12.busy), 0);
        chk("async_rst_in_ready", int'(bus12.in_ready), 0);
        chk("async_rst_res_valid", int'(bus12.res_valid), 0);
        chk("async_rst_result", int'(bus12.result), 0);
        chk("async_rst_mul_a", int'(bus12.mul_a), 0);
        chk("async_rst_mul_b", int'(bus12.mul_b), 0);
        #2;
        t_rst = 1'b0;
        @(posedge clk); #1;
        run_vec(v[5]);

        chk("scoreboard_empty", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
